// File: rtl/entrada_antirrebote.sv
// Input conditioning for the ALU operand path: two-flop synchronisers on every
// raw board input, a debounce FSM for the store push-button, and capture of the
// select switch and switch byte once per accepted press.
module entrada_antirrebote #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       sel_raw,
    input  logic [7:0] sw_raw,
    output logic [7:0] sw_out,
    output logic       sel_out,
    output logic       store_pulse,
    output logic       busy
);

    localparam int CntWidth = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntWidth-1:0] CntZero = '0;
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        Idle,
        DebPress,
        Capture,
        Strobe,
        Held,
        DebRelease
    } state_t;

    // Bit 9 is the button, bit 8 the select switch, bits 7:0 the data switches.
    logic [9:0]          rawMeta_q;
    logic [9:0]          rawSync_q;

    logic                btnS;
    logic                selS;
    logic [7:0]          swS;

    state_t              state_q;
    logic [CntWidth-1:0] cnt_q;
    logic [7:0]          swOut_q;
    logic                selOut_q;
    logic                storePulse_q;

    assign btnS = rawSync_q[9];
    assign selS = rawSync_q[8];
    assign swS  = rawSync_q[7:0];

    // Two-flop synchroniser bringing all asynchronous board inputs into clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rawMeta_q <= '0;
            rawSync_q <= '0;
        end else begin
            rawMeta_q <= {btn_raw, sel_raw, sw_raw};
            rawSync_q <= rawMeta_q;
        end
    end

    // Debounce FSM: counts consecutive stable samples, captures data on acceptance
    // and raises a single registered strobe the cycle after capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= Idle;
            cnt_q        <= CntZero;
            swOut_q      <= 8'h00;
            selOut_q     <= 1'b0;
            storePulse_q <= 1'b0;
        end else begin
            storePulse_q <= 1'b0;
            case (state_q)
                Idle: begin
                    if (btnS) begin
                        state_q <= DebPress;
                        cnt_q   <= CntOne;
                    end else begin
                        cnt_q   <= CntZero;
                    end
                end
                DebPress: begin
                    if (!btnS) begin
                        state_q <= Idle;
                        cnt_q   <= CntZero;
                    end else if (cnt_q == CntLast) begin
                        state_q  <= Capture;
                        swOut_q  <= swS;
                        selOut_q <= selS;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                Capture: begin
                    state_q      <= Strobe;
                    storePulse_q <= 1'b1;
                end
                Strobe: begin
                    state_q <= Held;
                    cnt_q   <= CntZero;
                end
                Held: begin
                    if (!btnS) begin
                        state_q <= DebRelease;
                        cnt_q   <= CntOne;
                    end
                end
                DebRelease: begin
                    if (btnS) begin
                        state_q <= Held;
                        cnt_q   <= CntZero;
                    end else if (cnt_q == CntLast) begin
                        state_q <= Idle;
                        cnt_q   <= CntZero;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                default: begin
                    state_q <= Idle;
                    cnt_q   <= CntZero;
                end
            endcase
        end
    end

    assign sw_out      = swOut_q;
    assign sel_out     = selOut_q;
    assign store_pulse = storePulse_q;
    assign busy        = (state_q != Idle);

endmodule

// File: tb/tb_entrada_antirrebote.sv
// Directed bench for entrada_antirrebote with DEBOUNCE_CYCLES = 4. Expected
// values are hand-derived edge by edge from the first edge sampling btn_raw = 1.
module tb_entrada_antirrebote;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       sel_raw;
    logic [7:0] sw_raw;
    logic [7:0] sw_out;
    logic       sel_out;
    logic       store_pulse;
    logic       busy;

    int         assertCount;
    int         failCount;
    int         pulseCount;
    logic [7:0] regA;
    logic [7:0] regB;
    logic       bounce [14];

    entrada_antirrebote #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .sel_raw    (sel_raw),
        .sw_raw     (sw_raw),
        .sw_out     (sw_out),
        .sel_out    (sel_out),
        .store_pulse(store_pulse),
        .busy       (busy)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream operand stage model: counts strobes and loads A or B.
    initial begin
        pulseCount = 0;
        regA = 8'h00;
        regB = 8'h00;
    end

    always @(negedge clk) begin
        if (store_pulse) begin
            pulseCount = pulseCount + 1;
            if (sel_out) regB = sw_out;
            else         regA = sw_out;
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assertCount = assertCount + 1;
        if (observed !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic btn, input logic sel, input logic [7:0] sw);
        btn_raw = btn;
        sel_raw = sel;
        sw_raw  = sw;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Main directed sequence.
    initial begin
        assertCount = 0;
        failCount   = 0;
        bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        step(2);
        checkOutput("reset sw_out", sw_out, 8'h00);
        checkOutput("reset sel_out", {7'd0, sel_out}, 8'h00);
        checkOutput("reset store_pulse", {7'd0, store_pulse}, 8'h00);
        checkOutput("reset busy", {7'd0, busy}, 8'h00);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h5A);
        step(3);

        $display("[TB] clean press");
        btn_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            checkOutput($sformatf("t1 pulse e%0d", k), {7'd0, store_pulse}, {7'd0, k == 7});
            checkOutput($sformatf("t1 busy e%0d", k), {7'd0, busy}, {7'd0, k >= 3});
            if (k == 5) checkOutput("t1 sw_out before capture", sw_out, 8'h00);
            if (k == 6) begin
                checkOutput("t1 sw_out at capture", sw_out, 8'h5A);
                checkOutput("t1 sel_out at capture", {7'd0, sel_out}, 8'h00);
            end
        end
        btn_raw = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            checkOutput($sformatf("t1 release busy r%0d", k), {7'd0, busy}, {7'd0, k < 6});
        end
        checkOutput("t1 strobe count", 8'(pulseCount), 8'd1);

        $display("[TB] bounce rejection");
        applyStimulus(1'b0, 1'b1, 8'hC3);
        for (int k = 0; k < 14; k++) begin
            btn_raw = bounce[k];
            step(1);
            if (k == 4) checkOutput("t2 busy mid bounce", {7'd0, busy}, 8'h01);
        end
        checkOutput("t2 strobe count", 8'(pulseCount), 8'd1);
        checkOutput("t2 sw_out kept", sw_out, 8'h5A);
        checkOutput("t2 sel_out kept", {7'd0, sel_out}, 8'h00);
        checkOutput("t2 busy idle", {7'd0, busy}, 8'h00);

        $display("[TB] release bounce");
        applyStimulus(1'b1, 1'b0, 8'h21);
        step(12);
        checkOutput("t3 strobe count press", 8'(pulseCount), 8'd2);
        btn_raw = 1'b0;
        step(2);
        btn_raw = 1'b1;
        step(1);
        btn_raw = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            checkOutput($sformatf("t3 busy l%0d", k), {7'd0, busy}, {7'd0, k < 6});
        end
        checkOutput("t3 strobe count release", 8'(pulseCount), 8'd2);
        checkOutput("t3 sw_out", sw_out, 8'h21);

        $display("[TB] back-to-back operands");
        applyStimulus(1'b1, 1'b0, 8'h12);
        step(12);
        checkOutput("t4 first sw_out", sw_out, 8'h12);
        checkOutput("t4 first sel_out", {7'd0, sel_out}, 8'h00);
        btn_raw = 1'b0;
        step(8);
        applyStimulus(1'b1, 1'b1, 8'h34);
        step(12);
        checkOutput("t4 second sw_out", sw_out, 8'h34);
        checkOutput("t4 second sel_out", {7'd0, sel_out}, 8'h01);
        checkOutput("t4 operand A", regA, 8'h12);
        checkOutput("t4 operand B", regB, 8'h34);
        checkOutput("t4 strobe count", 8'(pulseCount), 8'd4);
        btn_raw = 1'b0;
        step(8);

        $display("[TB] data change after capture");
        applyStimulus(1'b1, 1'b0, 8'h77);
        step(7);
        checkOutput("t5 strobe", {7'd0, store_pulse}, 8'h01);
        applyStimulus(1'b1, 1'b1, 8'hFF);
        step(8);
        checkOutput("t5 sw_out held", sw_out, 8'h77);
        checkOutput("t5 sel_out held", {7'd0, sel_out}, 8'h00);
        checkOutput("t5 busy held", {7'd0, busy}, 8'h01);
        btn_raw = 1'b0;
        step(8);
        checkOutput("t5 sw_out after release", sw_out, 8'h77);
        checkOutput("t5 busy idle", {7'd0, busy}, 8'h00);
        checkOutput("t5 strobe count", 8'(pulseCount), 8'd5);

        $display("[TB] reset during strobe");
        applyStimulus(1'b1, 1'b0, 8'hA5);
        step(7);
        checkOutput("t6 strobe before reset", {7'd0, store_pulse}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6 strobe cut", {7'd0, store_pulse}, 8'h00);
        checkOutput("t6 busy cut", {7'd0, busy}, 8'h00);
        checkOutput("t6 sw_out cleared", sw_out, 8'h00);
        #2;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            checkOutput($sformatf("t6 pulse e%0d", k), {7'd0, store_pulse}, {7'd0, k == 7});
            checkOutput($sformatf("t6 busy e%0d", k), {7'd0, busy}, {7'd0, k >= 3});
            if (k == 5) checkOutput("t6 sw_out before capture", sw_out, 8'h00);
            if (k == 6) checkOutput("t6 sw_out at capture", sw_out, 8'hA5);
        end
        btn_raw = 1'b0;
        step(8);
        checkOutput("t6 strobe count", 8'(pulseCount), 8'd6);
        checkOutput("t6 busy idle", {7'd0, busy}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/entrada_antirrebote.md
# entrada_antirrebote

Front-end conditioning stage for the ALU operand path. It synchronises the raw board inputs (8-bit switch bank, A/B select switch, store push-button) into the clock domain. It debounces the push-button and emits one clean, registered, single-cycle store strobe per physical press. The strobe, the captured select and the captured switch byte feed directly into the operand-register stage (`uio_6` ← `store_pulse`, `uio_7` ← `sel_out`, `sw` ← `sw_out`).

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples required to accept a press or release. Legal range is 2 or more; 50000 is 1 ms at 50 MHz.
- `clk` input 1: single system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset; all flops to reset values immediately.
- `btn_raw` input 1: raw store push-button, active high, bouncy, asynchronous.
- `sel_raw` input 1: raw select switch, asynchronous; 0 selects A, 1 selects B.
- `sw_raw` input 8: raw data switches, asynchronous, quasi-static.
- `sw_out` output 8: switch byte captured for the current press.
- `sel_out` output 1: select value captured for the current press.
- `store_pulse` output 1: one-cycle store strobe, driven directly from a flop.
- `busy` output 1: high whenever FSM is not in IDLE.

## Operation
- Synchronisers: `btn_raw`, `sel_raw` and each `sw_raw` bit pass through two flops, giving `btn_s`, `sel_s` and `sw_s`. No other logic reads raw inputs.
- Counter `cnt` width is $clog2(DEBOUNCE_CYCLES). The counter saturates only through the FSM rules below and never wraps.
- FSM states and transitions:
  - IDLE: if `btn_s`=1, go to DEB_PRESS and set cnt←1. Otherwise stay, with cnt←0.
  - DEB_PRESS:
    - `btn_s`=0: go to IDLE, cnt←0 (bounce rejected, no strobe).
    - `btn_s`=1 and cnt==N-1: go to CAPTURE. On this same edge, sw_out←sw_s and sel_out←sel_s.
    - Otherwise: cnt←cnt+1.
  - CAPTURE: go unconditionally to STROBE.
  - STROBE: go unconditionally to HELD, cnt←0.
  - HELD: if `btn_s`=0, go to DEB_RELEASE and set cnt←1. Otherwise stay.
  - DEB_RELEASE:
    - `btn_s`=1: go to HELD, cnt←0 (release bounce).
    - `btn_s`=0 and cnt==N-1: go to IDLE, cnt←0.
    - Otherwise: cnt←cnt+1.
- `store_pulse` is the registered decode of state==STROBE. It is never combinational.
- `sw_out`/`sel_out` change only on the edge entering CAPTURE. They hold until the next accepted press, so they are stable at least one full cycle before and throughout the strobe.
- Exactly one strobe is produced per accepted press. A new press is recognised only after a full debounced release returns the FSM to IDLE.
- Changes on `sel_raw`/`sw_raw` after capture do not affect outputs until the next press.

## Timing
- Reset values: `sw_out`=8'h00, `sel_out`=0, `store_pulse`=0, `busy`=0. State is IDLE, cnt=0, and all synchroniser flops are 0.
- Latency: let e1 be the first edge sampling `btn_raw`=1.
  - `btn_s` is high after e2.
  - The FSM takes its first high sample at e3.
  - CAPTURE is entered at e(N+2).
  - `store_pulse` is high from e(N+3) to e(N+4), exactly one cycle.
- Example with N=4: capture at e6, strobe high over e7–e8.
- Release: N consecutive low samples are needed before IDLE. The earliest next CAPTURE is therefore N+2 edges after IDLE is re-entered.
- `busy` rises on the edge entering DEB_PRESS and falls on the edge entering IDLE.
- Reset mid-operation, including during STROBE, takes effect asynchronously:
  - The strobe is cut immediately.
  - Outputs return to reset values.
  - After `rst` deasserts, a button still held is treated as a new press and fully re-debounced.
- Simultaneous events: a `btn_s` change on the same edge as cnt==N-1 follows the `btn_s`-first priority given in DEB_PRESS and DEB_RELEASE.

## Test plan
- Clean press, N=4, sw_raw=8'h5A, sel_raw=0, button held 20 cycles: one `store_pulse` of 1 cycle at e7; `sw_out`=8'h5A and `sel_out`=0 from e6; `busy` high e3 until release completes.
- Bounce rejection, N=4: button high for 3 sampled cycles, low, high 3, low: `store_pulse` never asserts; `sw_out` keeps its previous value; FSM back in IDLE.
- Release bounce: after an accepted press, toggle the button low 2 cycles, then high, then low ≥4 cycles: no second strobe; IDLE reached only after 4 consecutive low samples.
- Back-to-back operands: press with sel=0/sw=8'h12, release, then press with sel=1/sw=8'h34: two strobes; outputs (0,8'h12) then (1,8'h34); downstream stage shows A=8'h12, B=8'h34.
- Data change after capture: change sw_raw to 8'hFF during STROBE/HELD: `sw_out` stays at the captured value until the next press.
- Reset during STROBE: assert `rst` mid-cycle: `store_pulse`, `busy` and `sw_out` go to 0 immediately. With the button still held after release of `rst`, a new strobe appears N+3 edges after the first sampling edge.
